mem_arbiter: RTL and testbench

- Shares the SoC's single memory port between the RV32I core's instruction-fetch unit (IFU, read-only) and load/store unit (LSU, read/write).
- Sits between the core and the memory/bus in the soc top level.
- Arbitrates requests, tracks outstanding transactions in order, and routes each response back to its owner.
- Includes starvation protection for the IFU.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction-fetch unit and the load/store unit.
// Tracks outstanding transactions in order and routes each response back to its owner.
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ifu_req,
    input  logic [31:0] i_ifu_addr,
    output logic        o_ifu_gnt,
    output logic        o_ifu_rvalid,
    output logic [31:0] o_ifu_rdata,
    input  logic        i_lsu_req,
    input  logic        i_lsu_we,
    input  logic [3:0]  i_lsu_be,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    output logic        o_lsu_gnt,
    output logic        o_lsu_rvalid,
    output logic [31:0] o_lsu_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {LK_NONE, LK_IFU, LK_LSU} lock_t;

    lock_t                      lock_q, lock_d;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic [ST_W-1:0]            starve_q;
    logic                       err_q;

    logic        full, sel_lsu, sel_req, push, pop, head_lsu;
    logic [31:0] sel_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full = (count_q == FULL_CNT);

    // Lock holds the selection stable while the memory stalls an offered request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lock_q <= LK_NONE;
        else       lock_q <= lock_d;
    end

    always_comb begin
        lock_d  = lock_q;
        sel_lsu = i_lsu_req;
        case (lock_q)
            LK_LSU:  sel_lsu = 1'b1;
            LK_IFU:  sel_lsu = 1'b0;
            default: if (starve_q == STARVE_MAX && i_ifu_req) sel_lsu = 1'b0;
        endcase
        sel_req   = sel_lsu ? i_lsu_req : i_ifu_req;
        o_mem_req = sel_req & ~full;
        if (o_mem_req && !i_mem_gnt) lock_d = sel_lsu ? LK_LSU : LK_IFU;
        else if (o_mem_req)          lock_d = LK_NONE;
    end

    assign sel_addr    = sel_lsu ? i_lsu_addr : i_ifu_addr;
    assign o_mem_addr  = sel_addr & 32'hFFFF_FFFC;
    assign o_mem_we    = sel_lsu & i_lsu_we;
    assign o_mem_be    = sel_lsu ? i_lsu_be : 4'b1111;
    assign o_mem_wdata = sel_lsu ? i_lsu_wdata : 32'h0;

    assign push      = o_mem_req & i_mem_gnt;
    assign o_ifu_gnt = push & ~sel_lsu;
    assign o_lsu_gnt = push & sel_lsu;

    assign pop          = i_mem_rvalid & (count_q != '0);
    assign head_lsu     = owner_q[rd_ptr_q];
    assign o_ifu_rvalid = pop & ~head_lsu;
    assign o_lsu_rvalid = pop & head_lsu;
    assign o_ifu_rdata  = o_ifu_rvalid ? i_mem_rdata : 32'h0;
    assign o_lsu_rdata  = o_lsu_rvalid ? i_mem_rdata : 32'h0;

    assign o_busy = (count_q != '0);
    assign o_err  = err_q;

    // Owner storage is payload only; pointers and count decide validity
    always_ff @(posedge i_clk) begin
        if (push) owner_q[wr_ptr_q] <= sel_lsu;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (!i_ifu_req || o_ifu_gnt)
                starve_q <= '0;
            else if (o_lsu_gnt && starve_q != STARVE_MAX)
                starve_q <= starve_q + 1'b1;
            if (i_mem_rvalid && !pop) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int MAXO = 4;
    localparam int SL   = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_ifu_req = 1'b0;
    logic [31:0] i_ifu_addr = '0;
    logic        o_ifu_gnt, o_ifu_rvalid;
    logic [31:0] o_ifu_rdata;
    logic        i_lsu_req = 1'b0, i_lsu_we = 1'b0;
    logic [3:0]  i_lsu_be = '0;
    logic [31:0] i_lsu_addr = '0, i_lsu_wdata = '0;
    logic        o_lsu_gnt, o_lsu_rvalid;
    logic [31:0] o_lsu_rdata;
    logic        o_mem_req, o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_busy, o_err;

    mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ifu_req(i_ifu_req), .i_ifu_addr(i_ifu_addr),
        .o_ifu_gnt(o_ifu_gnt), .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rdata(o_ifu_rdata),
        .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_be(i_lsu_be),
        .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
        .o_lsu_gnt(o_lsu_gnt), .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Model state: queue of owners (1 = LSU), starvation count, lock, sticky error
    bit m_q[$];
    int m_starve   = 0;
    bit m_lock     = 0;
    bit m_lock_lsu = 0;
    bit m_err      = 0;
    bit last_ig    = 0;
    bit last_lg    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        bit          full, sel_lsu, e_req, e_ig, e_lg, pop, head_lsu, spurious;
        bit          e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd;
        #1;
        if (i_rst) begin
            m_q.delete();
            m_starve = 0; m_lock = 0; m_lock_lsu = 0; m_err = 0;
        end
        full = (m_q.size() == MAXO);
        if (m_lock)                          sel_lsu = m_lock_lsu;
        else if (m_starve == SL && i_ifu_req) sel_lsu = 0;
        else                                  sel_lsu = i_lsu_req;
        e_req    = (sel_lsu ? i_lsu_req : i_ifu_req) && !full;
        e_ig     = e_req && i_mem_gnt && !sel_lsu;
        e_lg     = e_req && i_mem_gnt && sel_lsu;
        e_we     = sel_lsu && i_lsu_we;
        e_be     = sel_lsu ? i_lsu_be : 4'hF;
        e_addr   = {(sel_lsu ? i_lsu_addr[31:2] : i_ifu_addr[31:2]), 2'b00};
        e_wd     = sel_lsu ? i_lsu_wdata : 32'h0;
        pop      = i_mem_rvalid && (m_q.size() > 0);
        head_lsu = pop ? m_q[0] : 1'b0;
        spurious = i_mem_rvalid && !pop;

        chk("mem_req",    o_mem_req,    e_req);
        chk("mem_we",     o_mem_we,     e_we);
        chk("mem_be",     o_mem_be,     e_be);
        chk("mem_addr",   o_mem_addr,   e_addr);
        chk("mem_wdata",  o_mem_wdata,  e_wd);
        chk("ifu_gnt",    o_ifu_gnt,    e_ig);
        chk("lsu_gnt",    o_lsu_gnt,    e_lg);
        chk("ifu_rvalid", o_ifu_rvalid, pop && !head_lsu);
        chk("lsu_rvalid", o_lsu_rvalid, pop && head_lsu);
        chk("ifu_rdata",  o_ifu_rdata,  (pop && !head_lsu) ? i_mem_rdata : 32'h0);
        chk("lsu_rdata",  o_lsu_rdata,  (pop && head_lsu) ? i_mem_rdata : 32'h0);
        chk("busy",       o_busy,       m_q.size() != 0);
        chk("err",        o_err,        m_err);
        last_ig = e_ig;
        last_lg = e_lg;

        @(posedge i_clk);
        if (!i_rst) begin
            if (pop) m_q.delete(0);
            if (e_ig || e_lg) m_q.push_back(e_lg);
            if (spurious) m_err = 1;
            if (e_req && !i_mem_gnt) begin
                m_lock = 1; m_lock_lsu = sel_lsu;
            end else if (e_req) begin
                m_lock = 0;
            end
            if (!i_ifu_req || e_ig)                  m_starve = 0;
            else if (e_lg && m_starve < SL)          m_starve = m_starve + 1;
        end
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        i_ifu_req = 0; i_lsu_req = 0; i_lsu_we = 0;
        i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int k = 0; k < 20 && m_q.size() > 0; k++) begin
            i_mem_rvalid = 1;
            i_mem_rdata  = $urandom;
            step();
        end
        i_mem_rvalid = 0;
        #1 chk("drain_busy", o_busy, 0);
    endtask

    task automatic rand_phase(input int n);
        for (int c = 0; c < n; c++) begin
            if (!i_ifu_req || last_ig) begin
                i_ifu_req  = ($urandom % 3) != 0;
                i_ifu_addr = $urandom;
            end
            if (!i_lsu_req || last_lg) begin
                i_lsu_req   = ($urandom % 2) != 0;
                i_lsu_we    = $urandom % 2;
                i_lsu_be    = $urandom % 16;
                i_lsu_addr  = $urandom;
                i_lsu_wdata = $urandom;
            end
            i_mem_gnt    = ($urandom % 4) != 0;
            i_mem_rvalid = (m_q.size() > 0) && (($urandom % 2) != 0);
            i_mem_rdata  = $urandom;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1;
        repeat (2) @(negedge i_clk);
        step();
        i_rst = 0;
        step();

        rand_phase(1500);

        // Reset in the middle of traffic with the LSU requesting
        idle_inputs();
        i_lsu_req = 1; i_lsu_addr = 32'h40; i_lsu_be = 4'hF;
        i_rst = 1;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ifu_rvalid", o_ifu_rvalid, 0);
        chk("rst_lsu_rvalid", o_lsu_rvalid, 0);
        chk("rst_lsu_gnt", o_lsu_gnt, 0);
        chk("rst_mem_req", o_mem_req, 1);
        step();
        step();
        i_rst = 0; i_mem_gnt = 1;
        #1 chk("rst_first_lsu_gnt", o_lsu_gnt, 1);
        step();
        drain();

        // Contention: LSU wins four times, then the starved IFU is forced through
        for (int k = 0; k < 10; k++) begin
            i_ifu_req = 1; i_ifu_addr = 32'h1000 + 32'(4 * k);
            i_lsu_req = 1; i_lsu_we = 0; i_lsu_be = 4'hF; i_lsu_addr = 32'h2000;
            i_mem_gnt = 1;
            i_mem_rvalid = (m_q.size() > 0); i_mem_rdata = 32'(k);
            #1;
            chk("contention_lsu_gnt", o_lsu_gnt, (k % 5) != 4);
            chk("contention_ifu_gnt", o_ifu_gnt, (k % 5) == 4);
            step();
        end
        drain();

        // Lock: stalled IFU request keeps the bus even after the LSU arrives
        i_ifu_req = 1; i_ifu_addr = 32'h0000_0103;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lock_mem_req", o_mem_req, 1);
            chk("lock_addr", o_mem_addr, 32'h0000_0100);
            chk("lock_ifu_gnt", o_ifu_gnt, 0);
            step();
        end
        i_lsu_req = 1; i_lsu_we = 1; i_lsu_be = 4'hC;
        i_lsu_addr = 32'h0000_0204; i_lsu_wdata = 32'hDEAD_BEEF;
        #1;
        chk("lock_hold_addr", o_mem_addr, 32'h0000_0100);
        chk("lock_hold_we", o_mem_we, 0);
        step();
        i_mem_gnt = 1;
        #1;
        chk("lock_ifu_win", o_ifu_gnt, 1);
        chk("lock_lsu_wait", o_lsu_gnt, 0);
        chk("lock_win_addr", o_mem_addr, 32'h0000_0100);
        step();
        i_ifu_req = 0;
        #1;
        chk("lock_lsu_next", o_lsu_gnt, 1);
        chk("lock_lsu_addr", o_mem_addr, 32'h0000_0204);
        chk("lock_lsu_be", o_mem_be, 4'hC);
        chk("lock_lsu_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        step();
        drain();

        // Ordering of responses across owners
        i_ifu_req = 1; i_ifu_addr = 32'h10; i_mem_gnt = 1;
        #1;
        chk("ord_ifu0_gnt", o_ifu_gnt, 1);
        chk("ord_ifu0_be", o_mem_be, 4'hF);
        chk("ord_ifu0_wdata", o_mem_wdata, 0);
        step();
        i_ifu_req = 0;
        i_lsu_req = 1; i_lsu_we = 1; i_lsu_be = 4'b0011;
        i_lsu_addr = 32'h20; i_lsu_wdata = 32'h1234_5678;
        #1;
        chk("ord_lsu_gnt", o_lsu_gnt, 1);
        chk("ord_lsu_we", o_mem_we, 1);
        chk("ord_lsu_be", o_mem_be, 4'b0011);
        step();
        i_lsu_req = 0; i_ifu_req = 1; i_ifu_addr = 32'h14;
        #1;
        chk("ord_ifu1_gnt", o_ifu_gnt, 1);
        chk("ord_ifu1_addr", o_mem_addr, 32'h14);
        step();
        idle_inputs();
        i_mem_rvalid = 1; i_mem_rdata = 32'hA;
        #1;
        chk("ord_r0_ifu_rvalid", o_ifu_rvalid, 1);
        chk("ord_r0_ifu_rdata", o_ifu_rdata, 32'hA);
        chk("ord_r0_lsu_rdata", o_lsu_rdata, 0);
        step();
        i_mem_rdata = 32'h0;
        #1;
        chk("ord_r1_lsu_rvalid", o_lsu_rvalid, 1);
        chk("ord_r1_ifu_rvalid", o_ifu_rvalid, 0);
        step();
        i_mem_rdata = 32'hB;
        #1;
        chk("ord_r2_ifu_rvalid", o_ifu_rvalid, 1);
        chk("ord_r2_ifu_rdata", o_ifu_rdata, 32'hB);
        step();
        drain();

        // Full: four grants, then the request is blocked until a response frees a slot
        i_lsu_req = 1; i_lsu_we = 0; i_lsu_be = 4'hF; i_lsu_addr = 32'h300; i_mem_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("full_fill_gnt", o_lsu_gnt, 1);
            step();
        end
        i_mem_rvalid = 1; i_mem_rdata = 32'h77;
        #1;
        chk("full_blocked_req", o_mem_req, 0);
        chk("full_pop_rvalid", o_lsu_rvalid, 1);
        step();
        #1;
        chk("full_reopen_req", o_mem_req, 1);
        chk("full_pushpop_gnt", o_lsu_gnt, 1);
        step();
        i_mem_rvalid = 0;
        #1 chk("full_after_pushpop_req", o_mem_req, 1);
        step();
        #1;
        chk("full_again_req", o_mem_req, 0);
        chk("full_again_busy", o_busy, 1);
        step();
        drain();

        // Spurious response sets a sticky error
        i_mem_rvalid = 1; i_mem_rdata = 32'h55;
        #1;
        chk("spur_ifu_rvalid", o_ifu_rvalid, 0);
        chk("spur_lsu_rvalid", o_lsu_rvalid, 0);
        chk("spur_err_before", o_err, 0);
        step();
        i_mem_rvalid = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("spur_err_sticky", o_err, 1);
            step();
        end
        i_rst = 1;
        step();
        i_rst = 0;
        #1 chk("spur_err_cleared", o_err, 0);

        // Responses left over from before a reset are treated as spurious
        i_lsu_req = 1; i_mem_gnt = 1; i_lsu_addr = 32'h400;
        step();
        step();
        idle_inputs();
        i_rst = 1;
        #1 chk("midrst_busy", o_busy, 0);
        step();
        i_rst = 0;
        i_mem_rvalid = 1;
        #1 chk("stale_lsu_rvalid", o_lsu_rvalid, 0);
        step();
        i_mem_rvalid = 0;
        #1 chk("stale_err", o_err, 1);
        step();
        i_rst = 1;
        step();
        i_rst = 0;
        step();

        rand_phase(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
